// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Streams UART bytes into instruction memory and stops once a
//               HALT instruction word has been written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int         NB_DATA          = 32,
    parameter int         NB_BYTE          = 8,
    parameter int         N_INSTRUCTIONS   = 64,
    parameter int         N_BYTE_REGISTERS = N_INSTRUCTIONS * 4,
    parameter int         NB_COUNT         = $clog2(N_BYTE_REGISTERS) + 1,
    parameter logic [5:0] HALT_OPCODE      = 6'b111111
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic [NB_BYTE-1:0]  o_write_data,
    output logic                o_write_enable,
    output logic                o_mem_reset,
    output logic [NB_COUNT-1:0] o_byte_count,
    output logic                o_busy,
    output logic                o_load_done,
    output logic                o_overflow
);

    localparam int                  NB_PENDING = NB_DATA - NB_BYTE;
    localparam logic [NB_COUNT-1:0] BYTE_CAP   = NB_COUNT'(N_BYTE_REGISTERS);
    localparam logic [NB_DATA-1:0]  OPCODE_MASK = {6'h3F, {(NB_DATA-6){1'b0}}};
    localparam logic [NB_DATA-1:0]  HALT_WORD   = {HALT_OPCODE, {(NB_DATA-6){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state, next_state;
    // Only the first three bytes of a word need storing; the fourth completes it.
    logic [NB_PENDING-1:0] pending, next_pending;
    logic [1:0]            lane, next_lane;
    logic [NB_COUNT-1:0]   next_count;
    logic [NB_BYTE-1:0]    next_write_data;
    logic                  next_write_enable;
    logic                  next_mem_reset;
    logic [NB_DATA-1:0]    completed_word;
    logic                  halt_hit;

    assign completed_word = {pending, i_rx_data};
    assign halt_hit       = ((completed_word & OPCODE_MASK) == HALT_WORD);

    always_comb begin
        next_state        = state;
        next_pending      = pending;
        next_lane         = lane;
        next_count        = o_byte_count;
        next_write_data   = o_write_data;
        next_write_enable = 1'b0;
        next_mem_reset    = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (i_start) begin
                    next_state     = CLEAR;
                    next_mem_reset = 1'b1;
                    next_count     = '0;
                    next_lane      = '0;
                    next_pending   = '0;
                end
            end
            CLEAR: begin
                next_state = LOAD;
            end
            LOAD: begin
                if (i_rx_valid) begin
                    if (o_byte_count == BYTE_CAP) begin
                        next_state = ERROR;
                    end else begin
                        next_write_data   = i_rx_data;
                        next_write_enable = 1'b1;
                        next_count        = o_byte_count + 1'b1;
                        next_pending      = {pending[NB_PENDING-NB_BYTE-1:0], i_rx_data};
                        next_lane         = lane + 2'd1;
                        if (lane == 2'd3 && halt_hit) begin
                            next_state = DONE;
                        end
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status flags are derived from the next state so they line up with it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state          <= IDLE;
            pending        <= '0;
            lane           <= '0;
            o_byte_count   <= '0;
            o_write_data   <= '0;
            o_write_enable <= 1'b0;
            o_mem_reset    <= 1'b0;
            o_busy         <= 1'b0;
            o_load_done    <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            state          <= next_state;
            pending        <= next_pending;
            lane           <= next_lane;
            o_byte_count   <= next_count;
            o_write_data   <= next_write_data;
            o_write_enable <= next_write_enable;
            o_mem_reset    <= next_mem_reset;
            o_busy         <= (next_state == CLEAR) || (next_state == LOAD);
            o_load_done    <= (next_state == DONE);
            o_overflow     <= (next_state == ERROR);
        end
    end

endmodule

`default_nettype wire
